// File: rtl/sparc_id_ex_pkg.sv
// Shared constants for the SPARC-subset ID/EX core: ALU opcodes, Bicc conditions,
// control-word bit positions and the branch-condition evaluator.
package sparc_id_ex_pkg;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_ADDX  = 4'b0001;
   localparam logic [3:0] ALU_SUB   = 4'b0010;
   localparam logic [3:0] ALU_SUBX  = 4'b0011;
   localparam logic [3:0] ALU_AND   = 4'b0100;
   localparam logic [3:0] ALU_OR    = 4'b0101;
   localparam logic [3:0] ALU_XOR   = 4'b0110;
   localparam logic [3:0] ALU_XNOR  = 4'b0111;
   localparam logic [3:0] ALU_ANDN  = 4'b1000;
   localparam logic [3:0] ALU_ORN   = 4'b1001;
   localparam logic [3:0] ALU_SLL   = 4'b1010;
   localparam logic [3:0] ALU_SRL   = 4'b1011;
   localparam logic [3:0] ALU_SRA   = 4'b1100;
   localparam logic [3:0] ALU_PASSA = 4'b1101;
   localparam logic [3:0] ALU_PASSB = 4'b1110;
   localparam logic [3:0] ALU_NOTB  = 4'b1111;

   typedef enum logic [3:0] {
      COND_N   = 4'b0000, COND_E   = 4'b0001, COND_LE  = 4'b0010, COND_L   = 4'b0011,
      COND_LEU = 4'b0100, COND_CS  = 4'b0101, COND_NEG = 4'b0110, COND_VS  = 4'b0111,
      COND_A   = 4'b1000, COND_NE  = 4'b1001, COND_G   = 4'b1010, COND_GE  = 4'b1011,
      COND_GU  = 4'b1100, COND_CC  = 4'b1101, COND_POS = 4'b1110, COND_VC  = 4'b1111
   } bicc_cond_e;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   localparam int CTRL_JMPL    = 15;
   localparam int CTRL_RW      = 14;
   localparam int CTRL_ALU_HI  = 13;
   localparam int CTRL_ALU_LO  = 10;
   localparam int CTRL_SE      = 9;
   localparam int CTRL_LOAD    = 8;
   localparam int CTRL_RF_EN   = 7;
   localparam int CTRL_SIZE_HI = 6;
   localparam int CTRL_SIZE_LO = 5;
   localparam int CTRL_MOD_CC  = 4;
   localparam int CTRL_CALL    = 3;
   localparam int CTRL_DM_EN   = 2;
   localparam int CTRL_B_INSTR = 1;
   localparam int CTRL_A       = 0;

   // The EX copy drops the two branch bits, so every index shifts down by two.
   localparam int EX_ALU_HI = CTRL_ALU_HI - 2;
   localparam int EX_ALU_LO = CTRL_ALU_LO - 2;
   localparam int EX_MOD_CC = CTRL_MOD_CC - 2;

   localparam logic [5:0] OP3_JMPL = 6'b111000;
   localparam logic [5:0] OP3_SLL  = 6'b100101;
   localparam logic [5:0] OP3_SRL  = 6'b100110;
   localparam logic [5:0] OP3_SRA  = 6'b100111;

   // cc is {N,Z,V,C}
   function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] cc);
      logic n, z, v, c, res;
      n = cc[3];
      z = cc[2];
      v = cc[1];
      c = cc[0];
      case (cond)
         COND_N:   res = 1'b0;
         COND_E:   res = z;
         COND_LE:  res = z | (n ^ v);
         COND_L:   res = n ^ v;
         COND_LEU: res = c | z;
         COND_CS:  res = c;
         COND_NEG: res = n;
         COND_VS:  res = v;
         COND_A:   res = 1'b1;
         COND_NE:  res = ~z;
         COND_G:   res = ~(z | (n ^ v));
         COND_GE:  res = ~(n ^ v);
         COND_GU:  res = ~(c | z);
         COND_CC:  res = ~c;
         COND_POS: res = ~n;
         COND_VC:  res = ~v;
         default:  res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/sparc_id_ex_core_alu.sv
// 32-bit combinational ALU for the EX stage; flags are {N,Z,V,C}, with C/V
// meaningful only for the add/sub family (C is borrow for subtraction).
module sparc_alu
   import sparc_id_ex_pkg::*;
(
   input  logic [3:0]  alu_op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        cin_i,
   output logic [31:0] result_o,
   output logic [3:0]  flags_o
);

   logic [32:0] wide_s;
   logic [31:0] res_s;
   logic        c_s;
   logic        v_s;

   // Operation select with carry/overflow for the arithmetic group
   always_comb begin
      wide_s = 33'd0;
      res_s  = 32'd0;
      c_s    = 1'b0;
      v_s    = 1'b0;
      case (alu_op_i)
         ALU_ADD, ALU_ADDX: begin
            wide_s = {1'b0, a_i} + {1'b0, b_i}
                   + {32'd0, (alu_op_i == ALU_ADDX) ? cin_i : 1'b0};
            res_s  = wide_s[31:0];
            c_s    = wide_s[32];
            v_s    = (a_i[31] == b_i[31]) && (res_s[31] != a_i[31]);
         end
         ALU_SUB, ALU_SUBX: begin
            wide_s = {1'b0, a_i} - {1'b0, b_i}
                   - {32'd0, (alu_op_i == ALU_SUBX) ? cin_i : 1'b0};
            res_s  = wide_s[31:0];
            c_s    = wide_s[32];
            v_s    = (a_i[31] != b_i[31]) && (res_s[31] != a_i[31]);
         end
         ALU_AND:   res_s = a_i & b_i;
         ALU_OR:    res_s = a_i | b_i;
         ALU_XOR:   res_s = a_i ^ b_i;
         ALU_XNOR:  res_s = ~(a_i ^ b_i);
         ALU_ANDN:  res_s = a_i & ~b_i;
         ALU_ORN:   res_s = a_i | ~b_i;
         ALU_SLL:   res_s = a_i << b_i[4:0];
         ALU_SRL:   res_s = a_i >> b_i[4:0];
         ALU_SRA:   res_s = $signed(a_i) >>> b_i[4:0];
         ALU_PASSA: res_s = a_i;
         ALU_PASSB: res_s = b_i;
         ALU_NOTB:  res_s = ~b_i;
         default:   res_s = 32'd0;
      endcase
   end

   assign result_o = res_s;
   assign flags_o  = {res_s[31], (res_s == 32'd0), v_s, c_s};

endmodule

// File: rtl/sparc_id_ex_core.sv
// SPARC-subset decode/execute core: combinational ID decode and Bicc evaluation,
// an ID/EX register feeding the ALU, and the PSR condition-code register.
module sparc_id_ex_core
   import sparc_id_ex_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         Clk,
   input  logic         R,
   input  logic [W-1:0] instr,
   input  logic         nop_s,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   output logic [15:0]  ctrl_id,
   output logic [13:0]  ex_ctrl,
   output logic [W-1:0] alu_out,
   output logic [3:0]   alu_flags,
   output logic [3:0]   psr_cc,
   output logic         psr_c,
   output logic         branch_taken
);

   logic [15:0]  ctrl_s;
   logic [5:0]   op3_s;
   logic [3:0]   arith_op_s;
   logic         arith_ok_s;
   logic [13:0]  ex_ctrl_d, ex_ctrl_q;
   logic [W-1:0] op_a_q, op_b_q;
   logic [3:0]   psr_d, psr_q;
   logic [3:0]   cc_s;
   logic         unused_s;

   assign op3_s    = instr[24:19];
   assign unused_s = ^instr[18:0];

   // Instruction decode into the 16-bit control word
   always_comb begin
      ctrl_s     = 16'd0;
      arith_op_s = ALU_ADD;
      arith_ok_s = 1'b1;
      case (instr[31:30])
         2'b00: begin
            case (instr[24:22])
               3'b010: begin
                  ctrl_s[CTRL_B_INSTR] = 1'b1;
                  ctrl_s[CTRL_A]       = instr[29];
               end
               3'b100: begin
                  ctrl_s[CTRL_ALU_HI:CTRL_ALU_LO] = ALU_PASSB;
                  ctrl_s[CTRL_RF_EN]              = 1'b1;
               end
               default: ctrl_s = 16'd0;
            endcase
         end
         2'b01: begin
            ctrl_s[CTRL_CALL]  = 1'b1;
            ctrl_s[CTRL_RF_EN] = 1'b1;
         end
         2'b10: begin
            if (op3_s == OP3_JMPL) begin
               ctrl_s[CTRL_JMPL]               = 1'b1;
               ctrl_s[CTRL_RF_EN]              = 1'b1;
               ctrl_s[CTRL_ALU_HI:CTRL_ALU_LO] = ALU_ADD;
            end else if (!op3_s[5]) begin
               // op3[4] selects the cc variant of each base operation
               case (op3_s[3:0])
                  4'b0000: arith_op_s = ALU_ADD;
                  4'b1000: arith_op_s = ALU_ADDX;
                  4'b0100: arith_op_s = ALU_SUB;
                  4'b1100: arith_op_s = ALU_SUBX;
                  4'b0001: arith_op_s = ALU_AND;
                  4'b0010: arith_op_s = ALU_OR;
                  4'b0011: arith_op_s = ALU_XOR;
                  4'b0111: arith_op_s = ALU_XNOR;
                  4'b0101: arith_op_s = ALU_ANDN;
                  4'b0110: arith_op_s = ALU_ORN;
                  default: arith_ok_s = 1'b0;
               endcase
               if (arith_ok_s) begin
                  ctrl_s[CTRL_ALU_HI:CTRL_ALU_LO] = arith_op_s;
                  ctrl_s[CTRL_RF_EN]              = 1'b1;
                  ctrl_s[CTRL_MOD_CC]             = op3_s[4];
               end else begin
                  ctrl_s = 16'd0;
               end
            end else begin
               case (op3_s)
                  OP3_SLL: begin
                     ctrl_s[CTRL_ALU_HI:CTRL_ALU_LO] = ALU_SLL;
                     ctrl_s[CTRL_RF_EN]              = 1'b1;
                  end
                  OP3_SRL: begin
                     ctrl_s[CTRL_ALU_HI:CTRL_ALU_LO] = ALU_SRL;
                     ctrl_s[CTRL_RF_EN]              = 1'b1;
                  end
                  OP3_SRA: begin
                     ctrl_s[CTRL_ALU_HI:CTRL_ALU_LO] = ALU_SRA;
                     ctrl_s[CTRL_RF_EN]              = 1'b1;
                  end
                  default: ctrl_s = 16'd0;
               endcase
            end
         end
         2'b11: begin
            case (op3_s)
               6'b000000: begin
                  ctrl_s[CTRL_LOAD]                 = 1'b1;
                  ctrl_s[CTRL_RF_EN]                = 1'b1;
                  ctrl_s[CTRL_DM_EN]                = 1'b1;
                  ctrl_s[CTRL_SIZE_HI:CTRL_SIZE_LO] = SIZE_WORD;
               end
               6'b000001, 6'b001001: begin
                  ctrl_s[CTRL_LOAD]                 = 1'b1;
                  ctrl_s[CTRL_RF_EN]                = 1'b1;
                  ctrl_s[CTRL_DM_EN]                = 1'b1;
                  ctrl_s[CTRL_SIZE_HI:CTRL_SIZE_LO] = SIZE_BYTE;
                  ctrl_s[CTRL_SE]                   = op3_s[3];
               end
               6'b000010, 6'b001010: begin
                  ctrl_s[CTRL_LOAD]                 = 1'b1;
                  ctrl_s[CTRL_RF_EN]                = 1'b1;
                  ctrl_s[CTRL_DM_EN]                = 1'b1;
                  ctrl_s[CTRL_SIZE_HI:CTRL_SIZE_LO] = SIZE_HALF;
                  ctrl_s[CTRL_SE]                   = op3_s[3];
               end
               6'b000100: begin
                  ctrl_s[CTRL_RW]                   = 1'b1;
                  ctrl_s[CTRL_DM_EN]                = 1'b1;
                  ctrl_s[CTRL_SIZE_HI:CTRL_SIZE_LO] = SIZE_WORD;
               end
               6'b000101: begin
                  ctrl_s[CTRL_RW]                   = 1'b1;
                  ctrl_s[CTRL_DM_EN]                = 1'b1;
                  ctrl_s[CTRL_SIZE_HI:CTRL_SIZE_LO] = SIZE_BYTE;
               end
               6'b000110: begin
                  ctrl_s[CTRL_RW]                   = 1'b1;
                  ctrl_s[CTRL_DM_EN]                = 1'b1;
                  ctrl_s[CTRL_SIZE_HI:CTRL_SIZE_LO] = SIZE_HALF;
               end
               default: ctrl_s = 16'd0;
            endcase
         end
         default: ctrl_s = 16'd0;
      endcase
   end

   assign ex_ctrl_d = ctrl_s[15:2] & ~{14{nop_s}};

   // PSR only follows the ALU when the instruction now in EX sets condition codes
   always_comb begin
      if (ex_ctrl_q[EX_MOD_CC]) begin
         psr_d = alu_flags;
      end else begin
         psr_d = psr_q;
      end
   end

   // ID/EX pipeline register and PSR
   always_ff @(posedge Clk or negedge R) begin
      if (!R) begin
         ex_ctrl_q <= 14'd0;
         op_a_q    <= '0;
         op_b_q    <= '0;
         psr_q     <= 4'b0000;
      end else begin
         ex_ctrl_q <= ex_ctrl_d;
         op_a_q    <= op_a;
         op_b_q    <= op_b;
         psr_q     <= psr_d;
      end
   end

   sparc_alu u_alu (
      .alu_op_i (ex_ctrl_q[EX_ALU_HI:EX_ALU_LO]),
      .a_i      (op_a_q),
      .b_i      (op_b_q),
      .cin_i    (psr_q[0]),
      .result_o (alu_out),
      .flags_o  (alu_flags)
   );

   // A cc-setting instruction in EX forwards its flags to the branch in ID
   assign cc_s         = ex_ctrl_q[EX_MOD_CC] ? alu_flags : psr_q;
   assign branch_taken = ctrl_s[CTRL_B_INSTR] & cond_true(instr[28:25], cc_s);

   assign ctrl_id = ctrl_s;
   assign ex_ctrl = ex_ctrl_q;
   assign psr_cc  = psr_q;
   assign psr_c   = psr_q[0];

endmodule

// File: tb/tb_sparc_id_ex_core.sv
// Self-checking bench for sparc_id_ex_core: EX results are predicted when an
// instruction is issued, queued, and compared one cycle later.
module tb_sparc_id_ex_core;

   logic        Clk = 1'b0;
   logic        R;
   logic [31:0] instr;
   logic        nop_s;
   logic [31:0] op_a, op_b;
   logic [15:0] ctrl_id;
   logic [13:0] ex_ctrl;
   logic [31:0] alu_out;
   logic [3:0]  alu_flags, psr_cc;
   logic        psr_c, branch_taken;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [13:0] ctrl;
      logic [31:0] out;
      logic [3:0]  flags;
   } exp_t;
   exp_t sb_q[$];
   exp_t e;

   sparc_id_ex_core dut (
      .Clk(Clk), .R(R), .instr(instr), .nop_s(nop_s), .op_a(op_a), .op_b(op_b),
      .ctrl_id(ctrl_id), .ex_ctrl(ex_ctrl), .alu_out(alu_out), .alu_flags(alu_flags),
      .psr_cc(psr_cc), .psr_c(psr_c), .branch_taken(branch_taken)
   );

   always #5 Clk = ~Clk;

   function automatic logic [31:0] f3(input logic [5:0] op3);
      return {2'b10, 5'd1, op3, 5'd2, 1'b0, 8'd0, 5'd3};
   endfunction

   function automatic logic [31:0] fmem(input logic [5:0] op3);
      return {2'b11, 5'd4, op3, 5'd5, 1'b1, 13'd8};
   endfunction

   function automatic logic [31:0] fbicc(input logic a, input logic [3:0] cond);
      return {2'b00, a, cond, 3'b010, 22'd0};
   endfunction

   // Reference ALU built on 64-bit arithmetic; returns {N,Z,V,C, result}
   function automatic logic [35:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic cin);
      longint sa, sb, s;
      logic [63:0] ua, ub;
      logic [31:0] r;
      logic c, v;
      logic [4:0] sh;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      sh = b[4:0];
      c = 1'b0;
      v = 1'b0;
      s = 0;
      r = 32'd0;
      case (op)
         4'd0, 4'd1: begin
            r = a + b + ((op == 4'd1) ? {31'd0, cin} : 32'd0);
            c = (ua + ub + ((op == 4'd1) ? {63'd0, cin} : 64'd0)) > 64'h0000_0000_FFFF_FFFF;
            s = sa + sb + ((op == 4'd1) ? longint'(cin) : 0);
            v = (s != longint'($signed(r)));
         end
         4'd2, 4'd3: begin
            r = a - b - ((op == 4'd3) ? {31'd0, cin} : 32'd0);
            c = ua < (ub + ((op == 4'd3) ? {63'd0, cin} : 64'd0));
            s = sa - sb - ((op == 4'd3) ? longint'(cin) : 0);
            v = (s != longint'($signed(r)));
         end
         4'd4:  r = a & b;
         4'd5:  r = a | b;
         4'd6:  r = a ^ b;
         4'd7:  r = ~(a ^ b);
         4'd8:  r = a & ~b;
         4'd9:  r = a | ~b;
         4'd10: r = a << sh;
         4'd11: r = a >> sh;
         4'd12: r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
         4'd13: r = a;
         4'd14: r = b;
         default: r = ~b;
      endcase
      return {r[31], (r == 32'd0), v, c, r};
   endfunction

   task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                        input logic nop, input logic [13:0] ectrl, input logic [3:0] aop,
                        input logic cin);
      exp_t x;
      logic [35:0] m;
      instr = ins;
      op_a  = a;
      op_b  = b;
      nop_s = nop;
      m = ref_alu(aop, a, b, cin);
      x.ctrl  = ectrl;
      x.out   = m[31:0];
      x.flags = m[35:32];
      sb_q.push_back(x);
   endtask

   task automatic idle();
      instr = 32'd0;
      op_a  = 32'd0;
      op_b  = 32'd0;
      nop_s = 1'b0;
   endtask

   task automatic test_reset();
      R = 1'b0;
      instr = f3(6'b010000);
      op_a = 32'h7FFF_FFFF;
      op_b = 32'd1;
      nop_s = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      n_cmp++; if (ex_ctrl !== 14'd0) begin n_err++; $display("FAIL rst_ex_ctrl got %h exp %h", ex_ctrl, 14'd0); end
      n_cmp++; if (psr_cc !== 4'b0000) begin n_err++; $display("FAIL rst_psr got %b exp 0000", psr_cc); end
      n_cmp++; if (alu_out !== 32'd0) begin n_err++; $display("FAIL rst_alu_out got %h exp 0", alu_out); end
      @(negedge Clk);
      R = 1'b1;
      #1;
      n_cmp++; if (ex_ctrl !== 14'd0) begin n_err++; $display("FAIL rel_hold_ctrl got %h exp 0", ex_ctrl); end
      n_cmp++; if (alu_out !== 32'd0) begin n_err++; $display("FAIL rel_hold_out got %h exp 0", alu_out); end
   endtask

   task automatic test_addcc();
      issue(f3(6'b010000), 32'h7FFF_FFFF, 32'd1, 1'b0, 14'h024, 4'd0, 1'b0);
      n_cmp++; if (ctrl_id !== 16'h0090) begin n_err++; $display("FAIL addcc_ctrl_id got %h exp 0090", ctrl_id); end
      @(posedge Clk); #1;
      e = sb_q.pop_front();
      n_cmp++; if (ex_ctrl !== e.ctrl) begin n_err++; $display("FAIL addcc_ex_ctrl got %h exp %h", ex_ctrl, e.ctrl); end
      n_cmp++; if (alu_out !== 32'h8000_0000) begin n_err++; $display("FAIL addcc_out got %h exp 80000000", alu_out); end
      n_cmp++; if (alu_flags !== 4'b1010) begin n_err++; $display("FAIL addcc_flags got %b exp 1010", alu_flags); end
      n_cmp++; if (psr_cc !== 4'b0000) begin n_err++; $display("FAIL addcc_psr_early got %b exp 0000", psr_cc); end
      idle();
      @(posedge Clk); #1;
      n_cmp++; if (psr_cc !== 4'b1010) begin n_err++; $display("FAIL addcc_psr got %b exp 1010", psr_cc); end
   endtask

   task automatic test_subcc_branch();
      issue(f3(6'b010100), 32'd5, 32'd5, 1'b0, 14'h224, 4'd2, 1'b0);
      @(posedge Clk); #1;
      e = sb_q.pop_front();
      n_cmp++; if (ex_ctrl !== e.ctrl) begin n_err++; $display("FAIL subcc_ex_ctrl got %h exp %h", ex_ctrl, e.ctrl); end
      n_cmp++; if (alu_out !== e.out || alu_flags !== 4'b0100) begin n_err++; $display("FAIL subcc_out got %h/%b exp %h/0100", alu_out, alu_flags, e.out); end
      instr = fbicc(1'b0, 4'b0001);
      #1;
      n_cmp++; if (ctrl_id !== 16'h0002) begin n_err++; $display("FAIL be_ctrl_id got %h exp 0002", ctrl_id); end
      n_cmp++; if (branch_taken !== 1'b1) begin n_err++; $display("FAIL be_fwd_taken got %b exp 1", branch_taken); end
      instr = fbicc(1'b1, 4'b1001);
      #1;
      n_cmp++; if (branch_taken !== 1'b0 || ctrl_id !== 16'h0003) begin n_err++; $display("FAIL bne_a got %b/%h exp 0/0003", branch_taken, ctrl_id); end
      @(posedge Clk); #1;
      n_cmp++; if (psr_cc !== 4'b0100) begin n_err++; $display("FAIL subcc_psr got %b exp 0100", psr_cc); end
      idle();
   endtask

   task automatic test_ldsb_decode();
      logic [31:0] ins_t [5];
      logic [15:0] exp_t5 [5];
      ins_t[0] = fmem(6'b001001); exp_t5[0] = 16'h0384;
      ins_t[1] = fmem(6'b000000); exp_t5[1] = 16'h01C4;
      ins_t[2] = fmem(6'b000110); exp_t5[2] = 16'h4024;
      ins_t[3] = f3(6'b111111);   exp_t5[3] = 16'h0000;
      ins_t[4] = f3(6'b111000);   exp_t5[4] = 16'h8080;
      for (int i = 0; i < 5; i++) begin
         instr = ins_t[i];
         #1;
         n_cmp++; if (ctrl_id !== exp_t5[i]) begin n_err++; $display("FAIL decode_%0d got %h exp %h", i, ctrl_id, exp_t5[i]); end
      end
      idle();
      #1;
      n_cmp++; if (ctrl_id !== 16'h0000) begin n_err++; $display("FAIL decode_zero got %h exp 0000", ctrl_id); end
   endtask

   task automatic test_nop();
      issue(f3(6'b010000), 32'h7FFF_FFFF, 32'd1, 1'b1, 14'h000, 4'd0, 1'b0);
      @(posedge Clk); #1;
      e = sb_q.pop_front();
      n_cmp++; if (ex_ctrl !== e.ctrl) begin n_err++; $display("FAIL nop_ex_ctrl got %h exp %h", ex_ctrl, e.ctrl); end
      n_cmp++; if (alu_out !== e.out) begin n_err++; $display("FAIL nop_out got %h exp %h", alu_out, e.out); end
      idle();
      @(posedge Clk); #1;
      n_cmp++; if (psr_cc !== 4'b0100) begin n_err++; $display("FAIL nop_psr got %b exp 0100", psr_cc); end
   endtask

   task automatic test_sra_call();
      issue(f3(6'b100111), 32'h8000_0000, 32'd4, 1'b0, 14'hC20, 4'd12, 1'b0);
      @(posedge Clk); #1;
      e = sb_q.pop_front();
      n_cmp++; if (ex_ctrl !== e.ctrl) begin n_err++; $display("FAIL sra_ex_ctrl got %h exp %h", ex_ctrl, e.ctrl); end
      n_cmp++; if (alu_out !== 32'hF800_0000) begin n_err++; $display("FAIL sra_out got %h exp F8000000", alu_out); end
      n_cmp++; if (alu_flags !== 4'b1000) begin n_err++; $display("FAIL sra_flags got %b exp 1000", alu_flags); end
      instr = {2'b01, 30'h0000_0123};
      #1;
      n_cmp++; if (ctrl_id !== 16'h0088 || branch_taken !== 1'b0) begin n_err++; $display("FAIL call_ctrl got %h/%b exp 0088/0", ctrl_id, branch_taken); end
      idle();
      @(posedge Clk); #1;
   endtask

   task automatic test_addx_subx();
      issue(f3(6'b010000), 32'hFFFF_FFFF, 32'd1, 1'b0, 14'h024, 4'd0, 1'b0);
      @(posedge Clk); #1;
      e = sb_q.pop_front();
      n_cmp++; if (alu_out !== e.out || alu_flags !== 4'b0101) begin n_err++; $display("FAIL carry_gen got %h/%b exp %h/0101", alu_out, alu_flags, e.out); end
      issue(f3(6'b001000), 32'd1, 32'd2, 1'b0, 14'h120, 4'd1, 1'b1);
      @(posedge Clk); #1;
      e = sb_q.pop_front();
      n_cmp++; if (psr_c !== 1'b1 || psr_cc !== 4'b0101) begin n_err++; $display("FAIL carry_psr got %b/%b exp 1/0101", psr_c, psr_cc); end
      n_cmp++; if (alu_out !== 32'd4 || ex_ctrl !== e.ctrl) begin n_err++; $display("FAIL addx got %h/%h exp 4/%h", alu_out, ex_ctrl, e.ctrl); end
      issue(f3(6'b001100), 32'd10, 32'd3, 1'b0, 14'h320, 4'd3, 1'b1);
      @(posedge Clk); #1;
      e = sb_q.pop_front();
      n_cmp++; if (alu_out !== 32'd6 || alu_flags !== 4'b0000) begin n_err++; $display("FAIL subx got %h/%b exp 6/0000", alu_out, alu_flags); end
      idle();
      @(posedge Clk); #1;
   endtask

   task automatic test_cond_table();
      // PSR holds N=0 Z=1 V=0 C=1 here
      logic [15:0] taken_tbl;
      taken_tbl = 16'b1100_1001_0011_0110;
      for (int c = 0; c < 16; c++) begin
         instr = fbicc(1'b0, c[3:0]);
         #1;
         n_cmp++; if (branch_taken !== taken_tbl[c]) begin n_err++; $display("FAIL cond_%0d got %b exp %b", c, branch_taken, taken_tbl[c]); end
      end
      idle();
   endtask

   task automatic test_back_to_back();
      logic [5:0] op3_tbl [13];
      logic [3:0] aop_tbl [13];
      op3_tbl = '{6'b000000, 6'b001000, 6'b000100, 6'b001100, 6'b000001, 6'b000010, 6'b000011,
                  6'b000111, 6'b000101, 6'b000110, 6'b100101, 6'b100110, 6'b100111};
      aop_tbl = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
      @(negedge Clk);
      for (int i = 0; i < 13; i++) begin
         issue(f3(op3_tbl[i]), $urandom, $urandom, 1'b0, {2'b00, aop_tbl[i], 8'b0010_0000}, aop_tbl[i], 1'b1);
         @(posedge Clk); #1;
         if (sb_q.size() == 0) begin
            n_cmp++; n_err++; $display("FAIL b2b_empty_%0d got 0 exp 1 entries", i);
         end else begin
            e = sb_q.pop_front();
            n_cmp++; if (ex_ctrl !== e.ctrl || alu_out !== e.out || alu_flags !== e.flags) begin
               n_err++; $display("FAIL b2b_%0d got %h/%h/%b exp %h/%h/%b", i, ex_ctrl, alu_out, alu_flags, e.ctrl, e.out, e.flags);
            end
         end
      end
      idle();
      @(posedge Clk); #1;
      n_cmp++; if (psr_cc !== 4'b0101) begin n_err++; $display("FAIL b2b_psr got %b exp 0101", psr_cc); end
   endtask

   task automatic test_reset_mid();
      issue(f3(6'b010000), 32'h7FFF_FFFF, 32'd1, 1'b0, 14'h024, 4'd0, 1'b0);
      @(posedge Clk); #2;
      e = sb_q.pop_front();
      R = 1'b0;
      #1;
      n_cmp++; if (ex_ctrl !== 14'd0 || psr_cc !== 4'd0 || alu_out !== 32'd0) begin n_err++; $display("FAIL midrst got %h/%b/%h exp 0/0000/0", ex_ctrl, psr_cc, alu_out); end
      n_cmp++; if (ctrl_id !== 16'h0090) begin n_err++; $display("FAIL midrst_ctrl_id got %h exp 0090", ctrl_id); end
      @(negedge Clk);
      R = 1'b1;
      idle();
   endtask

   initial begin
      test_reset();
      test_addcc();
      test_subcc_branch();
      test_ldsb_decode();
      test_nop();
      test_sra_call();
      test_addx_subx();
      test_cond_table();
      test_back_to_back();
      test_reset_mid();
      repeat (2) @(posedge Clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
